// File: rtl/se_squeeze_scale_unit_pkg.sv
// Shared types and helpers for the squeeze-and-excite frame engine.
// Holds the FSM state type, default geometry and the scale/saturate helper.
package se_squeeze_scale_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SCALE,
        REPLAY
    } state_t;

    // Default geometry: 16 channels of 8x8 pixels
    localparam int DEF_PIX   = 64;
    localparam int DEF_SHIFT = 6;
    localparam int DEF_TOTAL = 1024;

    // Arithmetic shift right by frac, then clamp to a signed dw-bit range
    function automatic logic signed [63:0] sat_scale(
        input logic signed [63:0] prod,
        input int                 dw,
        input int                 frac
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = prod >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/se_squeeze_scale_unit_if.sv
// Stream bundle for the SE engine: input, pool, scale and output channels.
// slave is the engine's view, master is the surrounding system's view.
interface se_squeeze_scale_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] pool_data;
    logic [CH_W-1:0]       pool_channel;
    logic                  pool_valid;
    logic                  pool_ready;
    logic [DATA_WIDTH-1:0] scale_data;
    logic                  scale_valid;
    logic                  scale_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]       out_channel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  frame_done;

    modport slave (
        input  in_data, in_valid, pool_ready,
        input  scale_data, scale_valid, out_ready,
        output in_ready, pool_data, pool_channel, pool_valid,
        output scale_ready, out_data, out_channel, out_valid,
        output busy, frame_done
    );

    modport master (
        output in_data, in_valid, pool_ready,
        output scale_data, scale_valid, out_ready,
        input  in_ready, pool_data, pool_channel, pool_valid,
        input  scale_ready, out_data, out_channel, out_valid,
        input  busy, frame_done
    );
endinterface

// File: rtl/se_squeeze_scale_unit_frame_buffer.sv
// Frame store: one write port, one read port, registered read data.
// Read data holds when re_i is low so the replay pipeline can stall.
module se_squeeze_scale_unit_frame_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Synchronous write and 1-cycle read
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/se_squeeze_scale_unit.sv
// SE frame engine: captures a CxHxW map, streams channel means out,
// takes per-channel scales back and replays the map scaled and saturated.
module se_squeeze_scale_unit
    import se_squeeze_scale_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int NUM_CHANNELS = 16,
    parameter int IN_HEIGHT    = 8,
    parameter int IN_WIDTH     = 8
) (
    input logic clk,
    input logic rst,
    se_squeeze_scale_unit_if.slave bus
);
    localparam int PIX   = IN_HEIGHT * IN_WIDTH;
    localparam int SHIFT = $clog2(PIX);
    localparam int TOTAL = NUM_CHANNELS * PIX;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ACCW  = DATA_WIDTH + SHIFT;
    localparam logic [AW-1:0] PIX_MASK = AW'(PIX - 1);

    if ((PIX & (PIX - 1)) != 0) begin : g_geom_check
        $error("IN_HEIGHT*IN_WIDTH must be a power of two");
    end

    state_t                 state_q;
    logic [AW-1:0]          idx_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic                   cap_done_q;
    logic                   pool_valid_q;
    logic [DATA_WIDTH-1:0]  pool_data_q;
    logic [DATA_WIDTH-1:0]  pool_d;
    logic [CW-1:0]          pool_ch_q;
    logic [CW-1:0]          sc_cnt_q;
    logic [DATA_WIDTH-1:0]  scale_q [NUM_CHANNELS];
    logic [AW:0]            rd_cnt_q;
    logic                   rd_v_q;
    logic [CW-1:0]          rd_ch_q;
    logic [AW-1:0]          out_cnt_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [DATA_WIDTH-1:0]  out_data_d;
    logic [CW-1:0]          out_ch_q;
    logic                   frame_done_q;
    logic                   in_rdy;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic signed [2*DATA_WIDTH-1:0] prod;

    wire in_acc   = bus.in_valid && in_rdy;
    wire sc_acc   = bus.scale_valid && (state_q == SCALE);
    wire adv      = !out_valid_q || bus.out_ready;
    wire rd_en    = (state_q == REPLAY) && adv && (rd_cnt_q < (AW+1)'(TOTAL));
    wire out_fire = out_valid_q && bus.out_ready;
    wire last_pix = (idx_q & PIX_MASK) == PIX_MASK;

    // Input acceptance: first beat taken straight from IDLE, pool backpressure in CAPTURE
    always_comb begin
        in_rdy = 1'b0;
        unique case (state_q)
            IDLE:    in_rdy = bus.in_valid;
            CAPTURE: in_rdy = !cap_done_q && !(pool_valid_q && !bus.pool_ready);
            default: in_rdy = 1'b0;
        endcase
    end

    // Channel accumulate/mean and the scaled, saturated replay product
    always_comb begin
        acc_d      = acc_q + ACCW'($signed(bus.in_data));
        pool_d     = DATA_WIDTH'(acc_d >>> SHIFT);
        prod       = $signed(rd_data) * $signed(scale_q[rd_ch_q]);
        out_data_d = DATA_WIDTH'(sat_scale(64'(prod), DATA_WIDTH, FRAC_BITS));
    end

    se_squeeze_scale_unit_frame_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (TOTAL),
        .ADDR_WIDTH(AW)
    ) u_buf (
        .clk    (clk),
        .we_i   (in_acc),
        .waddr_i(idx_q),
        .wdata_i(bus.in_data),
        .re_i   (rd_en),
        .raddr_i(rd_cnt_q[AW-1:0]),
        .rdata_o(rd_data)
    );

    // Scale register file, written in channel order during SCALE
    always_ff @(posedge clk) begin
        if (sc_acc) scale_q[sc_cnt_q] <= bus.scale_data;
    end

    // Frame FSM with capture, pool, scale-count and replay pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            cap_done_q   <= 1'b0;
            pool_valid_q <= 1'b0;
            pool_data_q  <= '0;
            pool_ch_q    <= '0;
            sc_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_v_q       <= 1'b0;
            rd_ch_q      <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.pool_ready) pool_valid_q <= 1'b0;
            if (in_acc) begin
                if (state_q == IDLE) state_q <= CAPTURE;
                if (last_pix) begin
                    acc_q        <= '0;
                    pool_valid_q <= 1'b1;
                    pool_data_q  <= pool_d;
                    pool_ch_q    <= CW'(idx_q >> SHIFT);
                end else begin
                    acc_q <= acc_d;
                end
                if (idx_q == AW'(TOTAL - 1)) begin
                    idx_q      <= '0;
                    cap_done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (state_q == CAPTURE && cap_done_q &&
                (!pool_valid_q || bus.pool_ready)) begin
                state_q    <= SCALE;
                cap_done_q <= 1'b0;
            end
            if (sc_acc) begin
                if (sc_cnt_q == CW'(NUM_CHANNELS - 1)) begin
                    sc_cnt_q <= '0;
                    state_q  <= REPLAY;
                end else begin
                    sc_cnt_q <= sc_cnt_q + 1'b1;
                end
            end
            if (state_q == REPLAY && adv) begin
                rd_v_q      <= rd_en;
                rd_ch_q     <= CW'(rd_cnt_q >> SHIFT);
                out_valid_q <= rd_v_q;
                if (rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;
                if (rd_v_q) begin
                    out_data_q <= out_data_d;
                    out_ch_q   <= rd_ch_q;
                end
            end
            if (out_fire) begin
                if (out_cnt_q == AW'(TOTAL - 1)) begin
                    out_cnt_q    <= '0;
                    rd_cnt_q     <= '0;
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end else begin
                    out_cnt_q <= out_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.pool_data    = pool_data_q;
    assign bus.pool_channel = pool_ch_q;
    assign bus.pool_valid   = pool_valid_q;
    assign bus.scale_ready  = (state_q == SCALE);
    assign bus.out_data     = out_data_q;
    assign bus.out_channel  = out_ch_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.frame_done   = frame_done_q;
endmodule
